// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL lock-detection blocks: default widths and
// the lock-detector state encoding.
package adpll_pkg;

  localparam int PDET_WIDTH_DEF = 8;
  localparam int CTRL_WIDTH_DEF = 5;

  localparam logic [1:0] ST_UNLOCKED  = 2'b00;
  localparam logic [1:0] ST_ACQUIRING = 2'b01;
  localparam logic [1:0] ST_LOCKED    = 2'b10;
  localparam logic [1:0] ST_HOLDOVER  = 2'b11;

  function automatic logic is_locked_state(input logic [1:0] st);
    case (st)
      ST_LOCKED, ST_HOLDOVER: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous clock.
// Emits a registered one-cycle strobe per rising edge of din.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic strobe
);

  logic [1:0] sync_r;
  logic       prev_r;
  logic       armed_r;
  logic       strobe_r;
  logic       rise_s;

  assign rise_s = sync_r[1] & ~prev_r;
  assign strobe = strobe_r;

  // Synchronise, detect edges; the first edge after reset only arms the strobe
  // so a level already high at release never produces a spurious sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r   <= 2'b00;
      prev_r   <= 1'b0;
      armed_r  <= 1'b0;
      strobe_r <= 1'b0;
    end else begin
      sync_r   <= {sync_r[0], din};
      prev_r   <= sync_r[1];
      armed_r  <= armed_r | rise_s;
      strobe_r <= rise_s & armed_r;
    end
  end

endmodule

// File: rtl/lock_detector.sv
// ADPLL lock detector: qualifies phase error and DCO code on each reference
// edge and runs the UNLOCKED/ACQUIRING/LOCKED/HOLDOVER decision machine.
module lock_detector
  import adpll_pkg::*;
#(
  parameter int PDET_WIDTH   = PDET_WIDTH_DEF,
  parameter int CTRL_WIDTH   = CTRL_WIDTH_DEF,
  parameter int LOCK_THRESH  = 2,
  parameter int DCO_TOL      = 1,
  parameter int LOCK_COUNT   = 64,
  parameter int UNLOCK_COUNT = 4,
  parameter int REF_TIMEOUT  = 1024
) (
  input  logic                         fpga_clk_i,
  input  logic                         reset_i,
  input  logic                         enable_i,
  input  logic                         ref_clk_i,
  input  logic signed [PDET_WIDTH-1:0] error_i,
  input  logic signed [CTRL_WIDTH-1:0] dco_cc_i,
  output logic                         locked_o,
  output logic [1:0]                   state_o,
  output logic                         loss_of_lock_o,
  output logic signed [CTRL_WIDTH-1:0] cc_at_lock_o
);

  localparam int HIT_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);
  localparam int TMO_W  = $clog2(REF_TIMEOUT + 1);

  localparam logic [HIT_W-1:0]  HIT_MAX  = HIT_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(UNLOCK_COUNT);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(REF_TIMEOUT - 1);

  logic                         strobe_s;
  logic signed [PDET_WIDTH:0]   err_ext_s;
  logic [PDET_WIDTH:0]          err_abs_s;
  logic signed [CTRL_WIDTH:0]   dco_diff_s;
  logic [CTRL_WIDTH:0]          dco_abs_s;
  logic                         in_win_s;

  logic [1:0]                   state_r,  state_n_s;
  logic [HIT_W-1:0]             hit_r,    hit_n_s,  hit_inc_s;
  logic [MISS_W-1:0]            miss_r,   miss_n_s, miss_inc_s;
  logic [TMO_W-1:0]             tmo_r,    tmo_n_s;
  logic signed [CTRL_WIDTH-1:0] cc_r,     cc_n_s;
  logic                         loss_r,   loss_n_s;
  logic                         locked_r;

  edge_sync u_edge_sync (
    .clk    (fpga_clk_i),
    .rst    (reset_i),
    .din    (ref_clk_i),
    .strobe (strobe_s)
  );

  assign err_ext_s  = {error_i[PDET_WIDTH-1], error_i};
  assign dco_diff_s = $signed({dco_cc_i[CTRL_WIDTH-1], dco_cc_i}) - $signed({cc_r[CTRL_WIDTH-1], cc_r});
  assign hit_inc_s  = (hit_r == HIT_MAX) ? hit_r : hit_r + 1'b1;
  assign miss_inc_s = (miss_r == MISS_MAX) ? miss_r : miss_r + 1'b1;

  // Window qualification; magnitudes carry one extra bit so the most negative code is representable.
  always_comb begin
    if (err_ext_s[PDET_WIDTH]) begin
      err_abs_s = $unsigned(-err_ext_s);
    end else begin
      err_abs_s = $unsigned(err_ext_s);
    end
    if (dco_diff_s[CTRL_WIDTH]) begin
      dco_abs_s = $unsigned(-dco_diff_s);
    end else begin
      dco_abs_s = $unsigned(dco_diff_s);
    end
    if (is_locked_state(state_r)) begin
      in_win_s = (err_abs_s <= (PDET_WIDTH + 1)'(LOCK_THRESH)) &&
                 (dco_abs_s <= (CTRL_WIDTH + 1)'(DCO_TOL));
    end else begin
      in_win_s = (err_abs_s <= (PDET_WIDTH + 1)'(LOCK_THRESH));
    end
  end

  // Next-state logic: disable first, then a reference sample, then timeout.
  always_comb begin
    state_n_s = state_r;
    hit_n_s   = hit_r;
    miss_n_s  = miss_r;
    tmo_n_s   = tmo_r;
    cc_n_s    = cc_r;
    loss_n_s  = 1'b0;
    if (!enable_i) begin
      state_n_s = ST_UNLOCKED;
      hit_n_s   = {HIT_W{1'b0}};
      miss_n_s  = {MISS_W{1'b0}};
      tmo_n_s   = {TMO_W{1'b0}};
      loss_n_s  = is_locked_state(state_r);
    end else if (strobe_s) begin
      tmo_n_s = {TMO_W{1'b0}};
      case (state_r)
        ST_UNLOCKED, ST_ACQUIRING: begin
          if (!in_win_s) begin
            state_n_s = ST_UNLOCKED;
            hit_n_s   = {HIT_W{1'b0}};
          end else if (hit_inc_s >= HIT_MAX) begin
            state_n_s = ST_LOCKED;
            hit_n_s   = {HIT_W{1'b0}};
            miss_n_s  = {MISS_W{1'b0}};
            cc_n_s    = dco_cc_i;
          end else begin
            state_n_s = ST_ACQUIRING;
            hit_n_s   = hit_inc_s;
          end
        end
        ST_LOCKED, ST_HOLDOVER: begin
          if (in_win_s) begin
            state_n_s = ST_LOCKED;
            miss_n_s  = {MISS_W{1'b0}};
          end else if (miss_inc_s >= MISS_MAX) begin
            state_n_s = ST_UNLOCKED;
            hit_n_s   = {HIT_W{1'b0}};
            miss_n_s  = {MISS_W{1'b0}};
            loss_n_s  = 1'b1;
          end else begin
            state_n_s = ST_HOLDOVER;
            miss_n_s  = miss_inc_s;
          end
        end
        default: begin
          state_n_s = ST_UNLOCKED;
          hit_n_s   = {HIT_W{1'b0}};
          miss_n_s  = {MISS_W{1'b0}};
        end
      endcase
    end else if (tmo_r == TMO_LAST) begin
      state_n_s = ST_UNLOCKED;
      hit_n_s   = {HIT_W{1'b0}};
      miss_n_s  = {MISS_W{1'b0}};
      tmo_n_s   = {TMO_W{1'b0}};
      loss_n_s  = is_locked_state(state_r);
    end else begin
      tmo_n_s = tmo_r + 1'b1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r  <= ST_UNLOCKED;
      hit_r    <= {HIT_W{1'b0}};
      miss_r   <= {MISS_W{1'b0}};
      tmo_r    <= {TMO_W{1'b0}};
      cc_r     <= {CTRL_WIDTH{1'b0}};
      loss_r   <= 1'b0;
      locked_r <= 1'b0;
    end else begin
      state_r  <= state_n_s;
      hit_r    <= hit_n_s;
      miss_r   <= miss_n_s;
      tmo_r    <= tmo_n_s;
      cc_r     <= cc_n_s;
      loss_r   <= loss_n_s;
      locked_r <= is_locked_state(state_n_s);
    end
  end

  assign locked_o       = locked_r;
  assign state_o        = state_r;
  assign loss_of_lock_o = loss_r;
  assign cc_at_lock_o   = cc_r;

endmodule

// File: tb/tb_lock_detector.sv
// Self-checking bench for lock_detector: directed scenarios plus randomized
// samples checked against a counting reference model.
module tb_lock_detector;

  localparam int PW  = 8;
  localparam int CW  = 5;
  localparam int THR = 2;
  localparam int TOL = 1;
  localparam int LC  = 8;
  localparam int UC  = 4;
  localparam int TMO = 64;

  logic                 fpga_clk_i = 1'b0;
  logic                 reset_i;
  logic                 enable_i;
  logic                 ref_clk_i;
  logic signed [PW-1:0] error_i;
  logic signed [CW-1:0] dco_cc_i;
  logic                 locked_o;
  logic [1:0]           state_o;
  logic                 loss_of_lock_o;
  logic signed [CW-1:0] cc_at_lock_o;

  lock_detector #(
    .PDET_WIDTH(PW), .CTRL_WIDTH(CW), .LOCK_THRESH(THR), .DCO_TOL(TOL),
    .LOCK_COUNT(LC), .UNLOCK_COUNT(UC), .REF_TIMEOUT(TMO)
  ) dut (
    .fpga_clk_i     (fpga_clk_i),
    .reset_i        (reset_i),
    .enable_i       (enable_i),
    .ref_clk_i      (ref_clk_i),
    .error_i        (error_i),
    .dco_cc_i       (dco_cc_i),
    .locked_o       (locked_o),
    .state_o        (state_o),
    .loss_of_lock_o (loss_of_lock_o),
    .cc_at_lock_o   (cc_at_lock_o)
  );

  always #5 fpga_clk_i = ~fpga_clk_i;

  int total = 0;
  int bad   = 0;

  // reference model: lock status, consecutive hit/miss counts, captured code
  bit m_locked;
  int m_hits, m_misses, m_cc, exp_loss;
  int loss_seen = 0, run = 0, max_run = 0;

  always @(posedge fpga_clk_i) begin
    #1;
    if (loss_of_lock_o === 1'b1) begin
      loss_seen++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] exp_state();
    if (!m_locked) return (m_hits == 0) ? 2'b00 : 2'b01;
    else           return (m_misses == 0) ? 2'b10 : 2'b11;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},  32'(state_o), 32'(exp_state()));
    check({tag, ".locked"}, 32'(locked_o), 32'(m_locked));
    check({tag, ".cc"},     32'($signed(cc_at_lock_o)), 32'(m_cc));
    check({tag, ".loss"},   32'(loss_seen), 32'(exp_loss));
  endtask

  task automatic model_sample(input int e, input int d);
    int  ae, ad;
    bit  inw;
    ae  = (e < 0) ? -e : e;
    ad  = (d - m_cc < 0) ? m_cc - d : d - m_cc;
    inw = (ae <= THR) && (!m_locked || ad <= TOL);
    if (!m_locked) begin
      if (inw) begin
        m_hits++;
        if (m_hits >= LC) begin
          m_locked = 1'b1; m_cc = d; m_hits = 0; m_misses = 0;
        end
      end else begin
        m_hits = 0;
      end
    end else if (inw) begin
      m_misses = 0;
    end else begin
      m_misses++;
      if (m_misses >= UC) begin
        m_locked = 1'b0; m_misses = 0; m_hits = 0; exp_loss++;
      end
    end
  endtask

  task automatic model_drop();
    if (m_locked) exp_loss++;
    m_locked = 1'b0; m_hits = 0; m_misses = 0;
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_hits = 0; m_misses = 0; m_cc = 0;
  endtask

  task automatic ref_pulse(input int e, input int d, input int hi, input int lo);
    @(negedge fpga_clk_i);
    error_i   = PW'(e);
    dco_cc_i  = CW'(d);
    ref_clk_i = 1'b1;
    repeat (hi) @(negedge fpga_clk_i);
    ref_clk_i = 1'b0;
    repeat (lo) @(negedge fpga_clk_i);
  endtask

  task automatic sample(input int e, input int d);
    ref_pulse(e, d, 5, 5);
    model_sample(e, d);
  endtask

  task automatic mid_cycle_reset(input string tag);
    @(posedge fpga_clk_i);
    #2 reset_i = 1'b1;
    #1;
    model_reset();
    check({tag, ".state"},  32'(state_o), 32'(0));
    check({tag, ".locked"}, 32'(locked_o), 32'(0));
    check({tag, ".cc"},     32'(cc_at_lock_o), 32'(0));
    check({tag, ".pulse"},  32'(loss_of_lock_o), 32'(0));
    @(negedge fpga_clk_i);
    reset_i = 1'b0;
    ref_pulse(0, 0, 5, 5);   // first edge after release is never a sample
    check_all({tag, ".after"});
  endtask

  initial begin
    int n, e, d;
    reset_i = 1'b1; enable_i = 1'b1; ref_clk_i = 1'b0;
    error_i = '0;   dco_cc_i = '0;
    exp_loss = 0;
    model_reset();
    repeat (3) @(negedge fpga_clk_i);
    check_all("reset");
    reset_i = 1'b0;
    ref_pulse(0, 0, 5, 5);
    check_all("prime");

    // acquisition: lock on the 8th in-window sample
    for (int i = 0; i < LC - 1; i++) sample(1, 3);
    check_all("acq7");
    sample(1, 3);
    check_all("acq8");

    // short excursion into holdover and back
    for (int i = 0; i < 3; i++) begin
      sample(5, 3);
      check_all("hold");
    end
    sample(0, 3);
    check_all("hold.back");

    // most negative error is out-of-window
    for (int i = 0; i < UC; i++) sample(-128, 3);
    check_all("neg128");

    // DCO code step
    for (int i = 0; i < LC; i++) sample(0, 3);
    check_all("relock");
    sample(0, 6);
    check_all("dco.step1");
    for (int i = 1; i < UC; i++) sample(0, 6);
    check_all("dco.unlock");

    // reference stops: forced unlock REF_TIMEOUT cycles after the last sample
    for (int i = 0; i < LC; i++) sample(0, 3);
    @(negedge fpga_clk_i);
    error_i = PW'(5); dco_cc_i = CW'(3); ref_clk_i = 1'b1;
    model_sample(5, 3);
    n = 0;
    while (state_o !== 2'b11 && n < 40) begin @(negedge fpga_clk_i); n++; end
    check("tmo.holdover", 32'(state_o), 32'(3));
    n = 0;
    while (loss_of_lock_o !== 1'b1 && n < TMO + 20) begin @(negedge fpga_clk_i); n++; end
    check("tmo.cycles", 32'(n), 32'(TMO));
    model_drop();
    check_all("tmo");
    ref_clk_i = 1'b0;
    repeat (3) @(negedge fpga_clk_i);

    // reset during acquisition, then during lock
    for (int i = 0; i < 3; i++) sample(0, 2);
    check_all("acq3");
    mid_cycle_reset("rst.acq");
    for (int i = 0; i < LC; i++) sample(-2, -5);
    check_all("lock.neg");
    mid_cycle_reset("rst.lock");

    // disable while locked
    for (int i = 0; i < LC; i++) sample(2, 7);
    @(negedge fpga_clk_i);
    enable_i = 1'b0;
    repeat (3) @(negedge fpga_clk_i);
    model_drop();
    check_all("disable");
    enable_i = 1'b1;

    // randomized samples
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) e = int'($urandom_range(0, 255)) - 128;
      else                            e = int'($urandom_range(0, 4)) - 2;
      if (m_locked) begin
        if ($urandom_range(0, 7) == 0) d = m_cc + 3;
        else                           d = m_cc + int'($urandom_range(0, 2)) - 1;
        if (d > 15)  d = 15;
        if (d < -16) d = -16;
      end else begin
        d = int'($urandom_range(0, 31)) - 16;
      end
      ref_pulse(e, d, int'($urandom_range(4, 8)), int'($urandom_range(4, 8)));
      model_sample(e, d);
      check_all("rand");
      if ($urandom_range(0, 49) == 0) begin
        enable_i = 1'b0;
        repeat (2) @(negedge fpga_clk_i);
        enable_i = 1'b1;
        model_drop();
        check_all("rand.dis");
      end
    end

    check("loss.width", 32'(max_run), 32'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
